wt_inval_queue: RTL and testbench



---
 rtl/wt_inval_queue.sv | 105 ++++++++++
 tb/tb_wt_inval_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wt_inval_queue.sv
// wt_inval_queue: line-aligned FIFO of snoop invalidation requests feeding
// the write-through D$ invalidation port. Optional duplicate-line coalescing
// is enabled by defining WT_INVAL_MERGE_EN; without it every accepted request
// is enqueued and merge_cnt_o is tied to zero.
module wt_inval_queue #(
   parameter int unsigned Depth       = 4,
   parameter int unsigned OffsetWidth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [63:0]                snoop_addr_i,
   input  logic                       snoop_valid_i,
   output logic                       snoop_ready_o,
   output logic [63:0]                inval_addr_o,
   output logic                       inval_valid_o,
   input  logic                       inval_ready_i,
   output logic [$clog2(Depth):0]     level_o,
   output logic [7:0]                 merge_cnt_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [63:0] AlignMask = {{(64 - OffsetWidth){1'b1}}, {OffsetWidth{1'b0}}};

   logic [63:0]     mem [Depth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [LvlW-1:0] level;
   logic [63:0]     aligned;
   logic            push;
   logic            pop;
   logic            hit;
   logic            enq;

   assign aligned       = snoop_addr_i & AlignMask;
   // Ready and valid depend only on registered occupancy, so a pop never
   // frees a slot for a push in the same cycle.
   assign snoop_ready_o = (level != LvlW'(Depth));
   assign inval_valid_o = (level != '0);
   assign inval_addr_o  = mem[rd_ptr];
   assign level_o       = level;

   assign push = snoop_valid_i && snoop_ready_o;
   assign pop  = inval_valid_o && inval_ready_i;
   assign enq  = push && !hit;

`ifdef WT_INVAL_MERGE_EN
   logic [7:0] merge_cnt;

   // Match the incoming line against pending entries; the head is excluded
   // while it pops so a request arriving after delivery is never lost.
   always_comb begin
      hit = 1'b0;
      for (int unsigned k = 0; k < Depth; k++) begin
         if ((LvlW'(k) < level) && !((k == 0) && pop) &&
             (mem[rd_ptr + PtrW'(k)] == aligned)) begin
            hit = 1'b1;
         end
      end
   end

   // Saturating count of coalesced requests.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         merge_cnt <= '0;
      end else if (push && hit && (merge_cnt != '1)) begin
         merge_cnt <= merge_cnt + 8'd1;
      end
   end

   assign merge_cnt_o = merge_cnt;
`else
   assign hit         = 1'b0;
   assign merge_cnt_o = '0;
`endif

   // Entry storage; contents are not reset, validity comes from level.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem[wr_ptr] <= aligned;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + PtrW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PtrW'(1);
         end
         case ({enq, pop})
            2'b10:   level <= level + LvlW'(1);
            2'b01:   level <= level - LvlW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_wt_inval_queue.sv
// Scoreboard bench for wt_inval_queue: stimulus pushes expected aligned
// addresses into a queue, a negedge monitor pops and compares on each pop.
module tb_wt_inval_queue;

   localparam logic [63:0] Mask = 64'hFFFF_FFFF_FFFF_FFF0;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [63:0] snoop_addr_i = '0;
   logic        snoop_valid_i = 1'b0;
   logic        snoop_ready_o;
   logic [63:0] inval_addr_o;
   logic        inval_valid_o;
   logic        inval_ready_i = 1'b0;
   logic [2:0]  level_o;
   logic [7:0]  merge_cnt_o;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q [$];
   logic [7:0]  exp_merge_cnt = 8'd0;

   wt_inval_queue #(.Depth(4), .OffsetWidth(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .snoop_addr_i (snoop_addr_i),
      .snoop_valid_i(snoop_valid_i),
      .snoop_ready_o(snoop_ready_o),
      .inval_addr_o (inval_addr_o),
      .inval_valid_o(inval_valid_o),
      .inval_ready_i(inval_ready_i),
      .level_o      (level_o),
      .merge_cnt_o  (merge_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every handshake on the invalidation port must match the oldest expected line.
   always @(negedge clk_i) begin
      if (!rst_i && inval_valid_o && inval_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver: got %h expected nothing", inval_addr_o);
         end else begin
            chk("deliver", inval_addr_o, exp_q.pop_front());
         end
      end
   end

   // One cycle of stimulus; starts and ends 1 time unit after a rising edge.
   task automatic step(input logic v, input logic [63:0] a, input logic r,
                       input logic exp_acc, input logic exp_mrg);
      snoop_valid_i = v;
      snoop_addr_i  = a;
      inval_ready_i = r;
      @(negedge clk_i);
      if (v) begin
         chk("snoop_ready", {63'd0, snoop_ready_o}, {63'd0, exp_acc});
         if (exp_acc && !exp_mrg) exp_q.push_back(a & Mask);
         if (exp_acc && exp_mrg) exp_merge_cnt++;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input logic r, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 64'd0, r, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic mrg;
`ifdef WT_INVAL_MERGE_EN
      mrg = 1'b1;
`else
      mrg = 1'b0;
`endif
      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_ready", {63'd0, snoop_ready_o}, 64'd1);
      chk("rst_valid", {63'd0, inval_valid_o}, 64'd0);
      chk("rst_level", {61'd0, level_o}, 64'd0);
      chk("rst_merge", {56'd0, merge_cnt_o}, 64'd0);
      rst_i = 1'b0;
      idle(1'b0, 2);

      // Alignment and one-cycle latency
      step(1'b1, 64'h0000_0000_8000_123C, 1'b0, 1'b1, 1'b0);
      chk("lat_valid", {63'd0, inval_valid_o}, 64'd1);
      chk("lat_addr", inval_addr_o, 64'h0000_0000_8000_1230);
      chk("lat_level", {61'd0, level_o}, 64'd1);
      idle(1'b1, 1);
      chk("lat_drain", {61'd0, level_o}, 64'd0);

      // Backpressure and full
      for (int i = 0; i < 5; i++)
         step(1'b1, 64'h1000 + 64'(i) * 64'h40 + 64'h7, 1'b0, (i < 4), 1'b0);
      chk("full_level", {61'd0, level_o}, 64'd4);
      chk("full_ready", {63'd0, snoop_ready_o}, 64'd0);
      step(1'b1, 64'h2000, 1'b1, 1'b0, 1'b0);
      chk("full_pop_level", {61'd0, level_o}, 64'd3);
      chk("full_pop_ready", {63'd0, snoop_ready_o}, 64'd1);
      idle(1'b1, 3);
      chk("full_drain", {61'd0, level_o}, 64'd0);

      // Streaming with wrap
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 64'hA000_0000 + 64'(i) * 64'h10 + 64'(i), 1'b1, 1'b1, 1'b0);
         chk("stream_level", {63'd0, (level_o <= 3'd1)}, 64'd1);
      end
      idle(1'b1, 1);
      chk("stream_drain", {61'd0, level_o}, 64'd0);
      chk("stream_pending", 64'(exp_q.size()), 64'd0);

      // Duplicate lines A, B, A, B under backpressure
      step(1'b1, 64'h5_0000, 1'b0, 1'b1, 1'b0);
      step(1'b1, 64'h6_0008, 1'b0, 1'b1, 1'b0);
      step(1'b1, 64'h5_000F, 1'b0, 1'b1, mrg);
      step(1'b1, 64'h6_0000, 1'b0, 1'b1, mrg);
      chk("merge_level", {61'd0, level_o}, mrg ? 64'd2 : 64'd4);
      chk("merge_cnt", {56'd0, merge_cnt_o}, {56'd0, exp_merge_cnt});
      idle(1'b1, 4);
      chk("merge_drain", {61'd0, level_o}, 64'd0);

      // Head-pop race: A pending, A pushed as A pops
      step(1'b1, 64'h7_0000, 1'b0, 1'b1, 1'b0);
      step(1'b1, 64'h7_0004, 1'b1, 1'b1, 1'b0);
      chk("race_level", {61'd0, level_o}, 64'd1);
      chk("race_merge", {56'd0, merge_cnt_o}, {56'd0, exp_merge_cnt});
      idle(1'b1, 1);
      chk("race_drain", {61'd0, level_o}, 64'd0);

      // Asynchronous reset mid-burst with 3 entries
      for (int i = 0; i < 3; i++)
         step(1'b1, 64'h9000 + 64'(i) * 64'h100, 1'b0, 1'b1, 1'b0);
      chk("pre_rst_level", {61'd0, level_o}, 64'd3);
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, inval_valid_o}, 64'd0);
      exp_q.delete();
      exp_merge_cnt = 8'd0;
      @(posedge clk_i);
      #1;
      chk("rst2_level", {61'd0, level_o}, 64'd0);
      chk("rst2_ready", {63'd0, snoop_ready_o}, 64'd1);
      chk("rst2_merge", {56'd0, merge_cnt_o}, 64'd0);
      rst_i = 1'b0;
      step(1'b1, 64'hC0DE_0123, 1'b0, 1'b1, 1'b0);
      chk("post_rst_addr", inval_addr_o, 64'hC0DE_0120);
      idle(1'b1, 1);
      chk("post_rst_drain", {61'd0, level_o}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
